// File: rtl/collatz_pkg.sv
// Shared types and helpers for the multi-lane Collatz range engine.
package collatz_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} top_state_t;
    typedef enum logic [1:0] {LN_FREE, LN_ITER, LN_PEND} lane_state_t;

    // Saturation value of a length counter of the given width (widths up to 31).
    function automatic logic [31:0] len_sat(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    // One Collatz step on a zero-extended operand; two guard bits let the
    // caller detect that 3n+1 no longer fits its own datapath width.
    function automatic logic [65:0] next_term(input logic [63:0] n);
        logic [65:0] w;
        w = {2'b00, n};
        return n[0] ? (w + (w << 1) + 66'd1) : (w >> 1);
    endfunction

endpackage

// File: rtl/collatz_lane.sv
// Single Collatz iterator: load a start value, count terms down to 1, then
// hold the result until the write arbiter acknowledges it.
module collatz_lane
    import collatz_pkg::*;
#(
    parameter int N_BITS     = 32,
    parameter int COUNT_BITS = 16,
    parameter int IDX_BITS   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic [N_BITS-1:0]     i_n,
    input  logic [IDX_BITS-1:0]   i_idx,
    input  logic                  i_ack,
    output logic                  o_free,
    output logic                  o_pend,
    output logic [COUNT_BITS-1:0] o_result,
    output logic [IDX_BITS-1:0]   o_index,
    output logic                  o_ovf,
    output logic                  o_zero
);

    localparam logic [COUNT_BITS-1:0] LEN_SAT = COUNT_BITS'(len_sat(COUNT_BITS));
    localparam logic [65:0]           N_MAX   = (66'd1 << N_BITS) - 66'd1;

    lane_state_t           r_state;
    logic [N_BITS-1:0]     r_n;
    logic [COUNT_BITS-1:0] r_len;
    logic [IDX_BITS-1:0]   r_idx;
    logic                  r_ovf;
    logic                  r_zero;

    logic [65:0] w_next;
    logic        w_ovf;

    assign w_next = next_term(64'(r_n));
    assign w_ovf  = w_next > N_MAX;

    assign o_free   = (r_state == LN_FREE);
    assign o_pend   = (r_state == LN_PEND);
    assign o_result = r_len;
    assign o_index  = r_idx;
    assign o_ovf    = r_ovf;
    assign o_zero   = r_zero;

    // Lane FSM: FREE -> ITER (one term per cycle) -> PEND -> FREE on ack.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= LN_FREE;
            r_n     <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                LN_FREE: begin
                    if (i_load) begin
                        r_n   <= i_n;
                        r_idx <= i_idx;
                        r_ovf <= 1'b0;
                        if (i_n == '0) begin
                            // Zero never reaches 1: report it right away.
                            r_len   <= '0;
                            r_zero  <= 1'b1;
                            r_state <= LN_PEND;
                        end else begin
                            r_len   <= COUNT_BITS'(1);
                            r_zero  <= 1'b0;
                            r_state <= LN_ITER;
                        end
                    end
                end
                LN_ITER: begin
                    if (r_n == N_BITS'(1)) begin
                        r_state <= LN_PEND;
                    end else if (r_len == LEN_SAT) begin
                        // Length no longer representable: report saturated value.
                        r_state <= LN_PEND;
                    end else if (w_ovf) begin
                        r_len   <= '0;
                        r_ovf   <= 1'b1;
                        r_state <= LN_PEND;
                    end else begin
                        r_n   <= N_BITS'(w_next);
                        r_len <= r_len + 1'b1;
                    end
                end
                LN_PEND: begin
                    if (i_ack) r_state <= LN_FREE;
                end
                default: r_state <= LN_FREE;
            endcase
        end
    end

endmodule

// File: rtl/collatz_range_multi.sv
// Collatz range engine: N_LANES iterators fill a RAM with sequence lengths
// for RAM_WORDS consecutive start values, tracking the maximum and errors.
module collatz_range_multi
    import collatz_pkg::*;
#(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8,
    parameter int N_LANES       = 4,
    parameter int N_BITS        = 32,
    parameter int COUNT_BITS    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_go,
    input  logic [N_BITS-1:0]        i_start,
    input  logic [RAM_ADDR_BITS-1:0] i_rd_addr,
    output logic [COUNT_BITS-1:0]    o_count,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [COUNT_BITS-1:0]    o_max_count,
    output logic [RAM_ADDR_BITS-1:0] o_max_index,
    output logic                     o_ovf,
    output logic                     o_zero_err
);

    localparam int            CW    = RAM_ADDR_BITS + 1;
    localparam logic [CW-1:0] WORDS = CW'(RAM_WORDS);

    top_state_t               r_state;
    logic [N_BITS-1:0]        r_base;
    logic [CW-1:0]            r_next_idx;
    logic [CW-1:0]            r_written;
    logic [COUNT_BITS-1:0]    r_count;
    logic                     r_busy;
    logic                     r_done;
    logic [COUNT_BITS-1:0]    r_max_count;
    logic [RAM_ADDR_BITS-1:0] r_max_index;
    logic                     r_ovf;
    logic                     r_zero_err;
    logic [COUNT_BITS-1:0]    r_mem [2**RAM_ADDR_BITS];

    logic [N_LANES-1:0]                    w_free, w_pend, w_lovf, w_lzero;
    logic [N_LANES-1:0]                    w_load, w_ack;
    logic [N_LANES-1:0][COUNT_BITS-1:0]    w_res;
    logic [N_LANES-1:0][RAM_ADDR_BITS-1:0] w_idx;

    logic                     w_run;
    logic [N_BITS-1:0]        w_load_n;
    logic                     w_wr_en;
    logic [RAM_ADDR_BITS-1:0] w_wr_addr;
    logic [COUNT_BITS-1:0]    w_wr_data;
    logic                     w_wr_ovf;
    logic                     w_wr_zero;
    logic                     w_max_upd;
    logic                     w_last_write;

    assign w_run    = (r_state == ST_RUN);
    assign w_load_n = r_base + N_BITS'(r_next_idx);

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        collatz_lane #(
            .N_BITS    (N_BITS),
            .COUNT_BITS(COUNT_BITS),
            .IDX_BITS  (RAM_ADDR_BITS)
        ) u_lane (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_load  (w_load[g]),
            .i_n     (w_load_n),
            .i_idx   (r_next_idx[RAM_ADDR_BITS-1:0]),
            .i_ack   (w_ack[g]),
            .o_free  (w_free[g]),
            .o_pend  (w_pend[g]),
            .o_result(w_res[g]),
            .o_index (w_idx[g]),
            .o_ovf   (w_lovf[g]),
            .o_zero  (w_lzero[g])
        );
    end

    // Dispatcher: load the lowest-numbered free lane while work remains.
    always_comb begin
        w_load = '0;
        if (w_run && (r_next_idx < WORDS)) begin
            for (int i = N_LANES - 1; i >= 0; i--) begin
                if (w_free[i]) begin
                    w_load    = '0;
                    w_load[i] = 1'b1;
                end
            end
        end
    end

    // Write arbiter: the lowest-numbered pending lane owns the RAM port.
    always_comb begin
        w_ack     = '0;
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        w_wr_ovf  = 1'b0;
        w_wr_zero = 1'b0;
        if (w_run) begin
            for (int i = N_LANES - 1; i >= 0; i--) begin
                if (w_pend[i]) begin
                    w_ack     = '0;
                    w_ack[i]  = 1'b1;
                    w_wr_en   = 1'b1;
                    w_wr_addr = w_idx[i];
                    w_wr_data = w_res[i];
                    w_wr_ovf  = w_lovf[i];
                    w_wr_zero = w_lzero[i];
                end
            end
        end
    end

    // Ties resolve to the lower index so the result is order-independent.
    assign w_max_upd = w_wr_en && ((w_wr_data > r_max_count) ||
                       ((w_wr_data == r_max_count) && (w_wr_addr < r_max_index)));
    assign w_last_write = w_wr_en && (r_written == WORDS - CW'(1));

    // Top FSM with sweep bookkeeping, max tracking and sticky flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_next_idx  <= '0;
            r_written   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_max_count <= '0;
            r_max_index <= '0;
            r_ovf       <= 1'b0;
            r_zero_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_go) begin
                        r_state     <= ST_RUN;
                        r_base      <= i_start;
                        r_next_idx  <= '0;
                        r_written   <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_max_count <= '0;
                        r_max_index <= '0;
                        r_ovf       <= 1'b0;
                        r_zero_err  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (|w_load) r_next_idx <= r_next_idx + CW'(1);
                    if (w_wr_en) begin
                        r_written <= r_written + CW'(1);
                        if (w_wr_ovf)  r_ovf      <= 1'b1;
                        if (w_wr_zero) r_zero_err <= 1'b1;
                    end
                    if (w_max_upd) begin
                        r_max_count <= w_wr_data;
                        r_max_index <= w_wr_addr;
                    end
                    if (w_last_write) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Result RAM write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
    end

    // Registered read port (read-first against a same-cycle write).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_count <= '0;
        else         r_count <= r_mem[i_rd_addr];
    end

    assign o_count     = r_count;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_max_count = r_max_count;
    assign o_max_index = r_max_index;
    assign o_ovf       = r_ovf;
    assign o_zero_err  = r_zero_err;

endmodule

// File: tb/tb_collatz_range_multi.sv
// Bench for collatz_range_multi: two configurations (4-lane/16-word and
// 1-lane/4-word with a 4-bit length), both with an 8-bit datapath.
module tb_collatz_range_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       go, sel;
    logic [7:0] start;
    logic [3:0] rd_addr;
    logic       rd_en;

    logic [15:0] cnt_m, maxc_m;
    logic [3:0]  maxi_m;
    logic        busy_m, done_m, ovf_m, zerr_m;
    logic [3:0]  cnt_s, maxc_s;
    logic [1:0]  maxi_s;
    logic        busy_s, done_s, ovf_s, zerr_s;

    logic [15:0] cnt, maxc;
    logic [3:0]  maxi;
    logic        busy, done, ovf, zerr;

    int checks = 0;
    int errors = 0;
    int exp_mem [16];
    int exp_max, exp_idx, exp_ovf, exp_zero;
    logic [3:0] rd_q;
    logic       rd_v;

    always #5 clk = ~clk;

    collatz_range_multi #(
        .RAM_WORDS(16), .RAM_ADDR_BITS(4), .N_LANES(4), .N_BITS(8), .COUNT_BITS(16)
    ) u_m (
        .i_clk(clk), .i_reset(rst), .i_go(go & ~sel), .i_start(start),
        .i_rd_addr(rd_addr), .o_count(cnt_m), .o_busy(busy_m), .o_done(done_m),
        .o_max_count(maxc_m), .o_max_index(maxi_m), .o_ovf(ovf_m), .o_zero_err(zerr_m)
    );

    collatz_range_multi #(
        .RAM_WORDS(4), .RAM_ADDR_BITS(2), .N_LANES(1), .N_BITS(8), .COUNT_BITS(4)
    ) u_s (
        .i_clk(clk), .i_reset(rst), .i_go(go & sel), .i_start(start),
        .i_rd_addr(rd_addr[1:0]), .o_count(cnt_s), .o_busy(busy_s), .o_done(done_s),
        .o_max_count(maxc_s), .o_max_index(maxi_s), .o_ovf(ovf_s), .o_zero_err(zerr_s)
    );

    always_comb begin
        cnt  = sel ? 16'(cnt_s)  : cnt_m;
        maxc = sel ? 16'(maxc_s) : maxc_m;
        maxi = sel ? 4'(maxi_s)  : maxi_m;
        busy = sel ? busy_s : busy_m;
        done = sel ? done_s : done_m;
        ovf  = sel ? ovf_s  : ovf_m;
        zerr = sel ? zerr_s : zerr_m;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sequence length straight from the definition; -1 marks 3n+1 overflow.
    function automatic int exp_len(input longint unsigned n, input int nb, input int cb);
        int sat;
        int len;
        sat = (1 << cb) - 1;
        len = 1;
        if (n == 0) return 0;
        while (n != 1) begin
            if (len == sat) return sat;
            if (n % 2 == 1) begin
                if (3 * n + 1 >= (64'd1 << nb)) return -1;
                n = 3 * n + 1;
            end else begin
                n = n / 2;
            end
            len++;
        end
        return len;
    endfunction

    task automatic build_model(input int st, input int words, input int cb);
        int v, r;
        exp_max = 0; exp_idx = 0; exp_ovf = 0; exp_zero = 0;
        for (int i = 0; i < words; i++) begin
            v = (st + i) % 256;
            if (v == 0) begin
                exp_zero = 1;
                r = 0;
            end else begin
                r = exp_len(longint'(v), 8, cb);
                if (r < 0) begin
                    exp_ovf = 1;
                    r = 0;
                end
            end
            exp_mem[i] = r;
            if (r > exp_max) begin
                exp_max = r;
                exp_idx = i;
            end
        end
    endtask

    // Compare process: during readback every cycle's outputs are checked.
    always @(posedge clk) begin
        rd_q <= rd_addr;
        rd_v <= rd_en;
    end

    always @(negedge clk) begin
        if (rd_v) begin
            chk("count", cnt, exp_mem[rd_q]);
            chk("max_count", maxc, exp_max);
            chk("max_index", maxi, exp_idx);
            chk("ovf", ovf, exp_ovf);
            chk("zero_err", zerr, exp_zero);
            chk("done", done, 1);
            chk("busy", busy, 0);
        end
    end

    task automatic run_sweep(input bit s, input int st, input bit glitch);
        int words, n;
        words = s ? 4 : 16;
        sel = s;
        build_model(st, words, s ? 4 : 16);
        @(posedge clk); #1;
        start = 8'(st);
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        chk("busy_after_go", busy, 1);
        chk("done_after_go", done, 0);
        if (glitch) begin
            repeat (3) @(posedge clk);
            #1;
            start = 8'(st + 50);
            go = 1'b1;
            @(posedge clk); #1;
            go = 1'b0;
        end
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got 0 expected 1");
        end
        for (int a = 0; a < words; a++) begin
            rd_addr = 4'(a);
            rd_en = 1'b1;
            @(posedge clk); #1;
        end
        rd_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_count"}, cnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_max_count"}, maxc, 0);
        chk({tag, "_max_index"}, maxi, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_zero_err"}, zerr, 0);
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; sel = 1'b0; start = '0; rd_addr = '0; rd_en = 1'b0;
        #12;
        check_idle("rst_m");
        sel = 1'b1; #1;
        check_idle("rst_s");
        rst = 1'b0;

        // Pin the model to hand-computed lengths.
        chk("model_27", exp_len(64'd27, 32, 16), 112);
        chk("model_6", exp_len(64'd6, 32, 16), 9);
        chk("model_3", exp_len(64'd3, 32, 16), 8);
        chk("model_sat7", exp_len(64'd7, 8, 4), 15);
        chk("model_ovf255", exp_len(64'd255, 8, 16), -1);

        // Single lane, 4 words: 1,2,8,3.
        run_sweep(1'b1, 1, 1'b0);
        chk("s1_max", maxc, 8);
        chk("s1_idx", maxi, 2);
        chk("s1_flags", {ovf, zerr}, 0);

        // Zero start: 0,1,2,8.
        run_sweep(1'b1, 0, 1'b0);
        chk("s0_zero", zerr, 1);
        chk("s0_idx", maxi, 3);

        // 255 overflows, wrap to 0 flags zero: 0,0,1,2.
        run_sweep(1'b1, 255, 1'b0);
        chk("s255_ovf", ovf, 1);
        chk("s255_zero", zerr, 1);
        chk("s255_max", maxc, 2);

        // 4-bit length saturates: 7..10 -> 15,4,15,7; tie keeps index 0.
        run_sweep(1'b1, 7, 1'b0);
        chk("s7_max", maxc, 15);
        chk("s7_idx", maxi, 0);

        // Four lanes, 16 words from 1: max 20 at n=9.
        run_sweep(1'b0, 1, 1'b0);
        chk("m1_max", maxc, 20);
        chk("m1_idx", maxi, 8);

        // Start 6 with a stray go mid-run: 18 and 19 tie at 21 -> index 12.
        run_sweep(1'b0, 6, 1'b1);
        chk("m6_max", maxc, 21);
        chk("m6_idx", maxi, 12);
        rd_addr = 4'd3;
        @(posedge clk); #1;
        chk("m6_rd3", cnt, 20);

        // Wrapping start on the wide instance.
        run_sweep(1'b0, 255, 1'b0);
        chk("m255_ovf", ovf, 1);
        chk("m255_zero", zerr, 1);
        chk("m255_idx", maxi, 10);

        // Reset mid-sweep aborts at once; a fresh sweep then completes.
        sel = 1'b0;
        @(posedge clk); #1;
        start = 8'd1; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_idle("midrst");
        #3;
        rst = 1'b0;
        run_sweep(1'b0, 1, 1'b0);
        chk("post_rst_max", maxc, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
